// File: rtl/fwb_pkg.sv
// Shared types and constants for the floating-point writeback arbiter.
//   fwb_entry_t : one queued FPU result (valid bit, destination, data)
//   fwb_src_e   : which producer drives the write port in a given cycle
package fwb_pkg;

  localparam int FREG_ADDR_W = 5;
  localparam int FREG_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [FREG_ADDR_W-1:0] rd;
    logic [FREG_DATA_W-1:0] data;
  } fwb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_BYPASS
  } fwb_src_e;

endpackage

// File: rtl/fwb_fifo.sv
// In-order FPU result queue with per-entry squash by destination register.
// Optional macro: FWB_PENDING_EN adds pend_mask (rd mask of valid entries).
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   push_i         : enqueue push_entry at the tail (caller guarantees not full)
//   pop_i          : drop the head (caller guarantees not empty)
//   squash_en/rd   : clear valid of every stored entry whose rd matches
//   head           : current head entry
//   empty, count   : occupancy
//   pend_mask      : (FWB_PENDING_EN) bit r set if a valid entry targets r
module fwb_fifo
  import fwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fwb_entry_t             push_entry,
  input  logic                   pop_i,
  input  logic                   squash_en,
  input  logic [FREG_ADDR_W-1:0] squash_rd,
  output fwb_entry_t             head,
  output logic                   empty,
  output logic [CW-1:0]          count
`ifdef FWB_PENDING_EN
  ,
  output logic [31:0]            pend_mask
`endif
);

  fwb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  // Popped slots get their valid bit cleared so that valid bits of
  // unoccupied slots are always 0; the pending mask relies on this.
  // The push is applied last so a freshly written entry is never squashed.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (squash_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == squash_rd) mem_d[i].valid = 1'b0;
      end
    end
    if (pop_i) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

`ifdef FWB_PENDING_EN
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid) pend_mask[mem_q[i].rd] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/float_wb_arbiter.sv
// Drives the FP register file write port from the load pipe (priority,
// never stalled) and the FPU (queued in fwb_fifo, bypassed when idle).
// Optional macro: FWB_PENDING_EN adds the fwb_pending output.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   ld_valid/ld_rd/ld_data        : load result, no backpressure
//   fpu_valid/fpu_rd/fpu_data     : FPU result, accepted when fpu_ready
//   fpu_ready                     : FIFO has room (count < DEPTH)
//   FRegWriteEn/FregD/Fdata_to_w  : registered write port
//   fwb_pending                   : (FWB_PENDING_EN) per-register pending mask
module float_wb_arbiter
  import fwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  input  logic [FREG_ADDR_W-1:0] ld_rd,
  input  logic [FREG_DATA_W-1:0] ld_data,
  input  logic                   fpu_valid,
  input  logic [FREG_ADDR_W-1:0] fpu_rd,
  input  logic [FREG_DATA_W-1:0] fpu_data,
  output logic                   fpu_ready,
  output logic                   FRegWriteEn,
  output logic [FREG_ADDR_W-1:0] FregD,
  output logic [FREG_DATA_W-1:0] Fdata_to_w
`ifdef FWB_PENDING_EN
  ,
  output logic [31:0]            fwb_pending
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fwb_entry_t     head, push_entry;
  logic           fifo_empty, push, pop, ld_take, fpu_xfer;
  logic [CW-1:0]  count;
  fwb_src_e       src;

  logic                   wr_en_q, wr_en_d;
  logic [FREG_ADDR_W-1:0] wr_rd_q, wr_rd_d;
  logic [FREG_DATA_W-1:0] wr_data_q, wr_data_d;

`ifdef FWB_PENDING_EN
  logic [31:0] fifo_pend;
`endif

  fwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_entry (push_entry),
    .pop_i      (pop),
    .squash_en  (ld_take),
    .squash_rd  (ld_rd),
    .head       (head),
    .empty      (fifo_empty),
    .count      (count)
`ifdef FWB_PENDING_EN
    ,
    .pend_mask  (fifo_pend)
`endif
  );

  assign fpu_ready = (count < DEPTH_C);

  always_comb begin
    ld_take  = ld_valid && (ld_rd != '0);
    fpu_xfer = fpu_valid && fpu_ready;

    src = SRC_NONE;
    if (ld_take)                            src = SRC_LOAD;
    else if (!fifo_empty)                   src = SRC_FIFO;
    else if (fpu_xfer && (fpu_rd != '0))    src = SRC_BYPASS;

    pop  = (src == SRC_FIFO);
    // rd=0 transfers are accepted but dropped; they never occupy a slot.
    push = fpu_xfer && (fpu_rd != '0) && (src != SRC_BYPASS);
    push_entry = '{valid: 1'b1, rd: fpu_rd, data: fpu_data};

    wr_en_d   = 1'b0;
    wr_rd_d   = '0;
    wr_data_d = '0;
    unique case (src)
      SRC_LOAD: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = ld_rd;
        wr_data_d = ld_data;
      end
      SRC_FIFO: begin
        // A squashed head is still popped, just without a write.
        if (head.valid) begin
          wr_en_d   = 1'b1;
          wr_rd_d   = head.rd;
          wr_data_d = head.data;
        end
      end
      SRC_BYPASS: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = fpu_rd;
        wr_data_d = fpu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign FRegWriteEn = wr_en_q;
  assign FregD       = wr_rd_q;
  assign Fdata_to_w  = wr_data_q;

`ifdef FWB_PENDING_EN
  always_comb begin
    fwb_pending = fifo_pend;
    if (wr_en_q) fwb_pending[wr_rd_q] = 1'b1;
    fwb_pending[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_float_wb_arbiter.sv
module tb_float_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        fpu_valid;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        fpu_ready;
  logic        FRegWriteEn;
  logic [4:0]  FregD;
  logic [31:0] Fdata_to_w;
`ifdef FWB_PENDING_EN
  logic [31:0] fwb_pending;
`endif

  float_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .fpu_valid   (fpu_valid),
    .fpu_rd      (fpu_rd),
    .fpu_data    (fpu_data),
    .fpu_ready   (fpu_ready),
    .FRegWriteEn (FRegWriteEn),
    .FregD       (FregD),
    .Fdata_to_w  (Fdata_to_w)
`ifdef FWB_PENDING_EN
    ,
    .fwb_pending (fwb_pending)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending FPU results, oldest first.
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } ment_t;

  ment_t     q[$];
  bit        exp_we;
  bit [4:0]  exp_rd;
  bit [31:0] exp_d;
  bit        last_accept;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("wr_en", {31'b0, FRegWriteEn}, {31'b0, exp_we});
    if (exp_we) begin
      check("wr_rd", {27'b0, FregD}, {27'b0, exp_rd});
      check("wr_data", Fdata_to_w, exp_d);
    end
`ifdef FWB_PENDING_EN
    begin
      bit [31:0] m;
      m = '0;
      foreach (q[i]) if (q[i].v) m[q[i].rd] = 1'b1;
      if (exp_we) m[exp_rd] = 1'b1;
      m[0] = 1'b0;
      check("pending", fwb_pending, m);
    end
`endif
  endtask

  // One clock: drive inputs, check readiness, advance model and DUT, check writes.
  task automatic step(input bit lv, input bit [4:0] lr, input bit [31:0] ld,
                      input bit fv, input bit [4:0] fr, input bit [31:0] fd);
    bit rdy, xfer, bypass;
    ld_valid = lv; ld_rd = lr; ld_data = ld;
    fpu_valid = fv; fpu_rd = fr; fpu_data = fd;
    #1;
    rdy = (q.size() < DEPTH);
    check("fpu_ready", {31'b0, fpu_ready}, {31'b0, rdy});
    xfer = fv && rdy;
    last_accept = xfer;
    bypass = 1'b0;
    exp_we = 1'b0; exp_rd = '0; exp_d = '0;
    if (lv && lr != 0) begin
      exp_we = 1'b1; exp_rd = lr; exp_d = ld;
      foreach (q[i]) if (q[i].rd == lr) q[i].v = 1'b0;
    end else if (q.size() > 0) begin
      ment_t h;
      h = q.pop_front();
      if (h.v) begin exp_we = 1'b1; exp_rd = h.rd; exp_d = h.d; end
    end else if (xfer && fr != 0) begin
      bypass = 1'b1;
      exp_we = 1'b1; exp_rd = fr; exp_d = fd;
    end
    if (xfer && fr != 0 && !bypass) q.push_back('{v: 1'b1, rd: fr, d: fd});
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    q.delete();
    exp_we = 1'b0; exp_rd = '0; exp_d = '0;
    check("rst_we", {31'b0, FRegWriteEn}, 32'd0);
    check("rst_rd", {27'b0, FregD}, 32'd0);
    check("rst_data", Fdata_to_w, 32'd0);
    check("rst_ready", {31'b0, fpu_ready}, 32'd1);
`ifdef FWB_PENDING_EN
    check("rst_pending", fwb_pending, 32'd0);
`endif
    rst_n = 1'b1;
    fpu_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int wr_cnt;
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0;
    @(posedge clk); #1;
    do_reset();

    // Single FPU result bypasses straight to the port.
    step(0, 0, 0, 1, 5'd3, 32'h3F80_0000);
    check("byp_rd", {27'b0, FregD}, 32'd3);
    check("byp_data", Fdata_to_w, 32'h3F80_0000);
    step(0, 0, 0, 0, 0, 0);
    check("byp_one_cycle", {31'b0, FRegWriteEn}, 32'd0);

    // Load stream fills the FIFO; rd=1..4 accepted, then stalled.
    acc = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 5'(16 + i), 32'h1000 + i, acc <= 6, 5'(acc), 32'h100 * acc);
      if (last_accept) acc++;
    end
    check("fill_accepted", acc - 1, 32'd4);
    #1 check("fill_not_ready", {31'b0, fpu_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("drain_rd", {27'b0, FregD}, i);
    end
    step(0, 0, 0, 0, 0, 0);

    // Queued rd=7 squashed by a younger load to rd=7.
    step(1, 5'd20, 32'h20, 1, 5'd7, 32'h77);
    step(1, 5'd21, 32'h21, 0, 0, 0);
    step(1, 5'd7, 32'hAA, 0, 0, 0);
    check("squash_ld_data", Fdata_to_w, 32'hAA);
    step(0, 0, 0, 0, 0, 0);
    check("squash_pop_no_we", {31'b0, FRegWriteEn}, 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Load and FPU to the same register in one cycle: load first, then FPU.
    step(1, 5'd5, 32'h1, 1, 5'd5, 32'h2);
    check("same_cyc_first", Fdata_to_w, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    check("same_cyc_second", Fdata_to_w, 32'h2);

    // rd=0 on both producers: no write, ready stays high.
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
      if (FRegWriteEn) wr_cnt++;
    end
    check("rd0_no_writes", wr_cnt, 32'd0);
    #1 check("rd0_ready", {31'b0, fpu_ready}, 32'd1);

    // Fill FIFO with writes in flight, then reset for one cycle.
    for (int i = 0; i < 5; i++) step(1, 5'(8 + i), 32'h800 + i, 1, 5'(24 + i), 32'h900 + i);
    do_reset();
    step(0, 0, 0, 0, 0, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit lv, fv;
      lv = ($urandom_range(0, 9) < 4);
      fv = ($urandom_range(0, 9) < 6);
      step(lv, 5'($urandom_range(0, 7)), $urandom, fv, 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
